// File: rtl/enemy_fire_scheduler.sv
// Round-robin enemy fire scheduler: one fire attempt every FIRE_PERIOD
// frames, one enemy examined per cycle, launch offered on a valid/ready pair.
module enemy_fire_scheduler #(
   parameter int ENEMY_COUNT = 17,
   parameter int SLOT_COUNT  = 4,
   parameter int FIRE_PERIOD = 30,
   localparam int EW = (ENEMY_COUNT > 1) ? $clog2(ENEMY_COUNT) : 1,
   localparam int SW = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1
) (
   input  logic                   clk25,
   input  logic                   reset,
   input  logic                   frame_tick,
   input  logic                   enable,
   input  logic [ENEMY_COUNT-1:0] enemy_alive,
   input  logic [SLOT_COUNT-1:0]  slot_busy,
   output logic                   launch_valid,
   input  logic                   launch_ready,
   output logic [SW-1:0]          launch_slot,
   output logic [EW-1:0]          launch_enemy,
   output logic [7:0]             fire_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      GRANT = 2'd2
   } state_t;

   localparam logic [7:0]    PER_LAST = 8'(FIRE_PERIOD - 1);
   localparam logic [EW-1:0] IDX_LAST = EW'(ENEMY_COUNT - 1);

   state_t        state_q, state_d;
   logic [7:0]    per_q, per_d;
   logic [EW-1:0] rr_ptr_q, rr_ptr_d;
   logic [EW-1:0] scan_idx_q, scan_idx_d;
   logic [EW-1:0] scan_cnt_q, scan_cnt_d;
   logic [SW-1:0] slot_q, slot_d;
   logic [EW-1:0] enemy_q, enemy_d;
   logic [7:0]    fire_cnt_q, fire_cnt_d;

   logic          cur_alive;
   logic          any_free;
   logic [SW-1:0] free_slot;

   function automatic logic [EW-1:0] wrap_inc(input logic [EW-1:0] v);
      return (v == IDX_LAST) ? '0 : v + 1'b1;
   endfunction

   always_comb begin
      cur_alive = 1'b0;
      for (int e = 0; e < ENEMY_COUNT; e++) begin
         if (scan_idx_q == EW'(e)) cur_alive = enemy_alive[e];
      end
   end

   // Downward walk so the lowest free index wins.
   always_comb begin
      free_slot = '0;
      for (int s = SLOT_COUNT - 1; s >= 0; s--) begin
         if (!slot_busy[s]) free_slot = SW'(s);
      end
      any_free = ~&slot_busy;
   end

   always_comb begin
      state_d    = state_q;
      per_d      = per_q;
      rr_ptr_d   = rr_ptr_q;
      scan_idx_d = scan_idx_q;
      scan_cnt_d = scan_cnt_q;
      slot_d     = slot_q;
      enemy_d    = enemy_q;
      fire_cnt_d = fire_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (frame_tick && enable) begin
               if (per_q == PER_LAST) begin
                  per_d      = '0;
                  scan_idx_d = rr_ptr_q;
                  scan_cnt_d = '0;
                  state_d    = SCAN;
               end else begin
                  per_d = per_q + 8'd1;
               end
            end
         end
         SCAN: begin
            if (cur_alive) begin
               if (any_free) begin
                  enemy_d = scan_idx_q;
                  slot_d  = free_slot;
                  state_d = GRANT;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               scan_idx_d = wrap_inc(scan_idx_q);
               scan_cnt_d = scan_cnt_q + 1'b1;
               if (scan_cnt_q == IDX_LAST) state_d = IDLE;
            end
         end
         GRANT: begin
            // Held until accepted; nothing but the handshake leaves here.
            if (launch_ready) begin
               rr_ptr_d   = wrap_inc(enemy_q);
               fire_cnt_d = fire_cnt_q + 8'd1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk25) begin
      if (reset) begin
         state_q    <= IDLE;
         per_q      <= '0;
         rr_ptr_q   <= '0;
         scan_idx_q <= '0;
         scan_cnt_q <= '0;
         slot_q     <= '0;
         enemy_q    <= '0;
         fire_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         per_q      <= per_d;
         rr_ptr_q   <= rr_ptr_d;
         scan_idx_q <= scan_idx_d;
         scan_cnt_q <= scan_cnt_d;
         slot_q     <= slot_d;
         enemy_q    <= enemy_d;
         fire_cnt_q <= fire_cnt_d;
      end
   end

   assign launch_valid = (state_q == GRANT);
   assign launch_slot  = slot_q;
   assign launch_enemy = enemy_q;
   assign fire_count   = fire_cnt_q;

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Randomized bench for enemy_fire_scheduler against a per-attempt
// outcome model (first alive enemy from the round-robin pointer).
module tb_enemy_fire_scheduler;

   localparam int EC = 17;
   localparam int SC = 4;
   localparam int FP = 3;
   localparam int EW = $clog2(EC);
   localparam int SW = $clog2(SC);

   logic          clk25 = 1'b0;
   logic          reset;
   logic          frame_tick;
   logic          enable;
   logic [EC-1:0] enemy_alive;
   logic [SC-1:0] slot_busy;
   logic          launch_valid;
   logic          launch_ready;
   logic [SW-1:0] launch_slot;
   logic [EW-1:0] launch_enemy;
   logic [7:0]    fire_count;

   int checks = 0;
   int errors = 0;
   int m_per;
   int m_ptr;
   int m_fc;
   int launches = 0;

   always #20 clk25 = ~clk25;

   enemy_fire_scheduler #(
      .ENEMY_COUNT(EC),
      .SLOT_COUNT (SC),
      .FIRE_PERIOD(FP)
   ) dut (
      .clk25       (clk25),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .enable      (enable),
      .enemy_alive (enemy_alive),
      .slot_busy   (slot_busy),
      .launch_valid(launch_valid),
      .launch_ready(launch_ready),
      .launch_slot (launch_slot),
      .launch_enemy(launch_enemy),
      .fire_count  (fire_count)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Issue frame ticks until the period model says an attempt fires;
   // returns with the attempt tick driven for the coming edge.
   task automatic tick_until_attempt();
      bit fired;
      int guard;
      fired = 0;
      guard = 0;
      while (!fired && guard < 200) begin
         guard++;
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk25);
            chk("idle_valid", launch_valid, 0);
            launch_ready = 1'($urandom_range(0, 1));
         end
         enable     = ($urandom_range(0, 3) != 0);
         frame_tick = 1'b1;
         if (enable) begin
            if (m_per == FP - 1) begin
               m_per = 0;
               fired = 1;
            end else begin
               m_per++;
            end
         end
         if (!fired) begin
            @(negedge clk25);
            frame_tick = 1'b0;
            chk("idle_valid", launch_valid, 0);
         end
      end
      if (!fired) chk("attempt_timeout", fired, 1);
   endtask

   task automatic attempt(input logic [EC-1:0] alive,
                          input logic [SC-1:0] busy,
                          input int hold_in, input bit rst_grant);
      bit found;
      int k;
      int slot;
      int hold;
      int n_scan;
      found = 0;
      k     = 0;
      slot  = -1;
      enemy_alive = alive;
      slot_busy   = busy;
      tick_until_attempt();
      for (int i = 0; i < EC; i++) begin
         if (!found && alive[(m_ptr + i) % EC]) begin
            found = 1;
            k     = i;
         end
      end
      for (int s = SC - 1; s >= 0; s--) if (!busy[s]) slot = s;
      n_scan = found ? k + 1 : EC;
      for (int n = 1; n <= n_scan; n++) begin
         @(negedge clk25);
         chk("scan_valid", launch_valid, 0);
         frame_tick   = 1'($urandom_range(0, 1));
         enable       = 1'($urandom_range(0, 1));
         launch_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk25);
      if (!found || slot < 0) begin
         chk("nolaunch_valid", launch_valid, 0);
         chk("nolaunch_fc", fire_count, m_fc);
         frame_tick = 1'b0;
         return;
      end
      chk("grant_valid", launch_valid, 1);
      chk("grant_enemy", launch_enemy, (m_ptr + k) % EC);
      chk("grant_slot", launch_slot, slot);
      hold = (hold_in < 0) ? $urandom_range(0, 4) : hold_in;
      launch_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         frame_tick  = 1'($urandom_range(0, 1));
         enable      = 1'($urandom_range(0, 1));
         enemy_alive = EC'($urandom);
         slot_busy   = SC'($urandom);
         @(negedge clk25);
         chk("hold_valid", launch_valid, 1);
         chk("hold_enemy", launch_enemy, (m_ptr + k) % EC);
         chk("hold_slot", launch_slot, slot);
      end
      if (rst_grant) begin
         reset = 1'b1;
         @(negedge clk25);
         reset      = 1'b0;
         frame_tick = 1'b0;
         chk("rst_valid", launch_valid, 0);
         chk("rst_enemy", launch_enemy, 0);
         chk("rst_slot", launch_slot, 0);
         chk("rst_fc", fire_count, 0);
         m_per = 0;
         m_ptr = 0;
         m_fc  = 0;
         return;
      end
      launch_ready = 1'b1;
      @(negedge clk25);
      frame_tick   = 1'b0;
      launch_ready = 1'($urandom_range(0, 1));
      m_fc  = (m_fc + 1) % 256;
      m_ptr = (m_ptr + k + 1) % EC;
      launches++;
      chk("post_valid", launch_valid, 0);
      chk("post_fc", fire_count, m_fc);
   endtask

   initial begin
      logic [EC-1:0] a;
      logic [SC-1:0] b;
      reset        = 1'b1;
      frame_tick   = 1'b0;
      enable       = 1'b0;
      launch_ready = 1'b0;
      enemy_alive  = '0;
      slot_busy    = '0;
      repeat (2) @(negedge clk25);
      chk("reset_valid", launch_valid, 0);
      chk("reset_slot", launch_slot, 0);
      chk("reset_enemy", launch_enemy, 0);
      chk("reset_fc", fire_count, 0);
      reset = 1'b0;
      m_per = 0;
      m_ptr = 0;
      m_fc  = 0;

      attempt('1, 4'b0000, 0, 0);
      attempt('1, 4'b0000, 0, 0);
      a = '0;
      a[5] = 1'b1;
      attempt(a, 4'b0000, -1, 0);
      attempt(a, 4'b0000, -1, 0);
      attempt('1, 4'b1111, -1, 0);
      attempt('1, 4'b1011, -1, 0);
      attempt('0, 4'b0000, -1, 0);
      attempt('1, 4'b0000, 10, 0);

      for (int t = 0; t < 2000 && (t < 300 || launches < 270); t++) begin
         case ($urandom_range(0, 4))
            0: a = '1;
            1: begin
               a = '0;
               a[$urandom_range(0, EC - 1)] = 1'b1;
            end
            2: a = EC'($urandom);
            3: a = '0;
            default: a = EC'($urandom) & EC'($urandom) & EC'($urandom);
         endcase
         b = ($urandom_range(0, 4) == 0) ? '1 : SC'($urandom);
         attempt(a, b, -1, 0);
      end

      attempt('1, 4'b0000, 2, 1);
      attempt('1, 4'b0000, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/enemy_fire_scheduler.md
ENEMY_FIRE_SCHEDULER -- requirements
Module: enemy_fire_scheduler

Interface
REQ-001 The block SHALL have parameter ENEMY_COUNT, default 17, the number of enemy sprites competing to fire.
REQ-002 The block SHALL have parameter SLOT_COUNT, default 4, the number of shared enemy-bullet slots.
REQ-003 The block SHALL have parameter FIRE_PERIOD, default 30, the number of frame_tick pulses between fire attempts (legal range 1-255).
REQ-004 clk25  input  1  25 MHz pixel clock; the only clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 frame_tick  input  1  one-cycle pulse per video frame.
REQ-007 enable  input  1  high permits new fire attempts.
REQ-008 enemy_alive  input  ENEMY_COUNT  bit e high = enemy e alive.
REQ-009 slot_busy  input  SLOT_COUNT  bit s high = bullet slot s in flight.
REQ-010 launch_valid  output  1  launch command pending.
REQ-011 launch_ready  input  1  bullet controller accepts the command.
REQ-012 launch_slot  output  clog2(SLOT_COUNT)  slot to load.
REQ-013 launch_enemy  output  clog2(ENEMY_COUNT)  index of the firing enemy.
REQ-014 fire_count  output  8  accepted launches, modulo 256.

Function
REQ-015 The block SHALL implement states IDLE, SCAN and GRANT.
REQ-016 IDLE: period counter SHALL increment on each frame_tick while enable=1 and hold while enable=0.
REQ-017 IDLE: frame_tick with counter = FIRE_PERIOD-1 and enable=1 SHALL clear the counter, load scan_idx <= rr_ptr and scan_cnt <= 0, and enter SCAN next cycle.
REQ-018 The period counter SHALL hold in SCAN and GRANT; frame_tick there is ignored.
REQ-019 SCAN SHALL examine exactly one enemy per cycle, enemy_alive[scan_idx].
REQ-020 SCAN, enemy alive and any slot_busy bit low: latch launch_enemy <= scan_idx, launch_slot <= lowest-index free slot, enter GRANT.
REQ-021 SCAN, enemy alive and all slots busy: return to IDLE with no launch; rr_ptr unchanged.
REQ-022 SCAN, enemy dead: scan_idx <= (scan_idx+1) mod ENEMY_COUNT, scan_cnt++; after ENEMY_COUNT dead examinations return to IDLE with no launch.
REQ-023 launch_valid SHALL equal 1 exactly while in GRANT; launch_slot and launch_enemy SHALL stay stable throughout GRANT.
REQ-024 GRANT SHALL never retract launch_valid before a cycle with launch_ready=1, regardless of enable, enemy_alive or slot_busy changes.
REQ-025 Handshake cycle (GRANT and launch_ready=1): rr_ptr <= (launch_enemy+1) mod ENEMY_COUNT, fire_count++ (255 wraps to 0), IDLE next cycle.
REQ-026 launch_ready outside GRANT SHALL have no effect.
REQ-027 Latency: attempt tick in cycle T with first alive enemy at offset k from rr_ptr gives launch_valid high in cycle T+2+k.
REQ-028 enable deasserted in SCAN or GRANT SHALL not abort the attempt in progress.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE, period counter 0, rr_ptr 0, scan_idx 0, scan_cnt 0, launch_valid 0, launch_slot 0, launch_enemy 0, fire_count 0; reset has priority over every other input.
REQ-030 reset asserted during GRANT SHALL drop launch_valid the following cycle with no fire_count increment.

Verification (FIRE_PERIOD=3, ENEMY_COUNT=17, SLOT_COUNT=4)
REQ-031 All alive, slot_busy=0000, ready tied 1, three ticks -> launch_valid high 2 cycles after 3rd tick, launch_enemy=0, launch_slot=0, fire_count=1; next attempt enemy 1.
REQ-032 Only enemy 5 alive, rr_ptr=0 -> launch_valid 7 cycles after attempt tick, launch_enemy=5; rr_ptr becomes 6; next attempt wraps to enemy 5 again after 16 dead examinations.
REQ-033 slot_busy=1111 with alive enemies -> no launch_valid, counter restarts; slot_busy=1011 -> launch_slot=2.
REQ-034 All enemies dead -> SCAN lasts 17 cycles, IDLE, no launch, fire_count unchanged.
REQ-035 GRANT with ready=0 for 10 cycles while enable, enemy_alive, slot_busy toggle -> valid/slot/enemy stable; ready=1 -> single handshake, fire_count+1.
REQ-036 reset pulsed during GRANT, and fire_count at 255 then handshake -> valid 0 after reset with all outputs 0; wrap case gives fire_count=0.
